cell_sequencer: RTL and testbench
=================================

// Module: cell_sequencer
// PURPOSE
//  Job-level controller for the cell processor. Walks an output image in raster order and
//  fetches each 3x3 neighbourhood from image memory A (and optionally B), edge-clamped.
//  Packs the neighbourhoods into cellA/cellB and drives opcode/userInputA. Captures
//  processedPixel and writes it to the output memory. Sits between the frame-buffer
//  read/write ports and the cellProcessor_int imagePorts side.
// PARAMETERS
//  IMG_W        64   image width in pixels (>=2)
//  IMG_H        64   image height in pixels (>=2)
//  PROC_LAT     1    cycles from cell/opcode stable to processedPixel valid (>=0)
//  ADDR_W       $clog2(IMG_W*IMG_H)   memory address width (derived)
// PORTS
//  clk          in   1            clock
//  rst          in   1            reset, asynchronous, active-low
//  start        in   1            job request; sampled in IDLE only
//  abort        in   1            cancel current job
//  cfg_opcode   in   opCodeWidth  opcode for job, latched at start
//  cfg_user     in   userInput_t  user operand, latched at start
//  cfg_two_src  in   1            1: fetch image B as well
//  busy         out  1            job in progress
//  done         out  1            1-cycle pulse, job completed normally
//  rd_en        out  1            memory read strobe
//  rd_sel       out  1            0 = image A, 1 = image B
//  rd_addr      out  ADDR_W       y*IMG_W + x
//  rd_data      in   pixel_t      valid exactly 1 cycle after rd_en
//  wr_en        out  1            output-memory write strobe
//  wr_addr      out  ADDR_W       output pixel address
//  wr_data      out  pixel_t      processed pixel
//  cell_a       out  cellDepth    to cellA
//  cell_b       out  cellDepth    to cellB
//  user_a       out  userInput_t  to userInputA
//  opcode       out  opCodeWidth  to opcode
//  proc_pixel   in   pixel_t      from processedPixel
// BEHAVIOUR
//  - Reset (rst=0, async): every output is 0. The FSM is in IDLE and the x/y counters are 0.
//  - FSM: IDLE -> FETCH_A -> [FETCH_B if two_src] -> WAIT -> WRITE -> (next pixel FETCH_A | DONE) -> IDLE.
//  - IDLE: on start=1, latch cfg_opcode, cfg_user and cfg_two_src. Set busy=1 next cycle and set x=y=0.
//    start while busy is ignored.
//  - FETCH_A/B: 10 cycles. rd_en=1 on cycles 0..8 for tap k=0..8, raster order (dy,dx) from
//    (-1,-1) to (+1,+1). rd_data is captured on cycles 1..9 into tap k, bits [8k+7:8k].
//  - Clamping: neighbour x' = min(max(x+dx,0),IMG_W-1); y' likewise. No out-of-range address is ever issued.
//  - cell_b = 0 when two_src=0. opcode/user_a hold the latched values for the whole job.
//  - WAIT: PROC_LAT+1 cycles, with cell_a/cell_b stable throughout.
//  - WRITE: wr_en=1 for 1 cycle, wr_data=proc_pixel, wr_addr=y*IMG_W+x. Then advance x;
//    on x==IMG_W-1, wrap x to 0 and increment y. After the last pixel (IMG_W-1,IMG_H-1), go to DONE.
//  - Cycles per pixel: 10 + 10*two_src + (PROC_LAT+1) + 1.
//  - DONE: done=1 for 1 cycle and busy=0 in the same cycle; IDLE follows.
//  - abort=1 in any non-IDLE state: go to IDLE next cycle. busy, rd_en and wr_en go low that cycle.
//    No further writes occur and done is not pulsed. abort has priority over WRITE in the same cycle,
//    so that write is suppressed. abort in IDLE has no effect.
//  - start and abort asserted together in IDLE: abort wins and no job starts.
//  - wr_en and rd_en are never high in the same cycle.
// STRUCTURE
//  - CellProcessingPkg: cellDepth (=72, 9 taps x 8b), opCodeWidth, pixel_t (8b), userInput_t,
//    and the new constants CELL_TAPS=9 and seq_state_e (FSM enum).
//  - Sub-module cell_addr_gen: combinational (x,y,k) -> clamped address.
//  - The top level is wired to cellProcessor_int imagePorts plus processedPixel.
// TESTING  (IMG_W=IMG_H=4, PROC_LAT=1, processor model returns centre tap of cell_a)
//  - Ramp image A (p=addr), start, opcode=3 -> 16 writes with wr_data==wr_addr in raster order.
//    done pulses 16*13 cycles after busy rises.
//  - Pixel (0,0) -> cell_a taps = {p0,p0,p1,p0,p0,p1,p4,p4,p5} (tap0 first).
//    Pixel (3,3) -> clamped to p10,p11,p11,p14,p15,p15,p14,p15,p15.
//  - two_src=1, B = 255-A -> rd_sel is 9x0 then 9x1 per pixel. cell_b taps = 255-A taps.
//    Per pixel the cycle count is 23.
//  - abort during FETCH_B of pixel 5 -> busy=0 next cycle, no wr_en afterwards, no done.
//    A following start completes all 16 writes.
//  - start pulsed mid-job, and cfg_opcode changed mid-job -> ignored; opcode output is unchanged,
//    there is exactly one done, and there are 16 writes.
//  - rst low during WAIT -> all outputs 0 in the same cycle (async). After release, IDLE with busy=0
//    until the next start.

Source files
------------

// File: rtl/cell_sequencer_pkg.sv
// Shared types and constants for the cell sequencer: pixel/cell widths,
// operand types and the sequencer FSM encoding.
package cell_sequencer_pkg;

    localparam int PIXEL_W   = 8;
    localparam int CELL_TAPS = 9;
    localparam int CELL_W    = CELL_TAPS * PIXEL_W;
    localparam int OPCODE_W  = 4;
    localparam int USER_W    = 8;
    localparam int TAP_W     = 4;

    typedef logic [PIXEL_W-1:0]  pixel_t;
    typedef logic [CELL_W-1:0]   cell_t;
    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [USER_W-1:0]   user_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_WAIT,
        S_WRITE,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/cell_sequencer_addr_gen.sv
// Combinational neighbourhood address: pixel (x,y) plus tap k (raster 3x3,
// k=0 is (-1,-1)) clamped to the image edges, returned as y*IMG_W+x.
module cell_addr_gen
    import cell_sequencer_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    parameter int X_W    = $clog2(IMG_W),
    parameter int Y_W    = $clog2(IMG_H)
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [TAP_W-1:0]  k,
    output logic [ADDR_W-1:0] addr
);

    int xc;
    int yc;

    // NOTE: every variable gets a value on every path, so no latch is inferred.
    always_comb begin
        xc = int'(x) + (int'(k) % 3) - 1;
        yc = int'(y) + (int'(k) / 3) - 1;
        if (xc < 0)
            xc = 0;
        else if (xc > IMG_W - 1)
            xc = IMG_W - 1;
        if (yc < 0)
            yc = 0;
        else if (yc > IMG_H - 1)
            yc = IMG_H - 1;
        addr = ADDR_W'(yc * IMG_W + xc);
    end

endmodule

// File: rtl/cell_sequencer.sv
// Job-level controller: walks the output image in raster order, fetches each
// edge-clamped 3x3 neighbourhood from A (and B), waits for the processor, writes the result.
module cell_sequencer
    import cell_sequencer_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int PROC_LAT = 1,
    parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  opcode_t           cfg_opcode,
    input  user_t             cfg_user,
    input  logic              cfg_two_src,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic              rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  pixel_t            rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output pixel_t            wr_data,
    output cell_t             cell_a,
    output cell_t             cell_b,
    output user_t             user_a,
    output opcode_t           opcode,
    input  pixel_t            proc_pixel
);

    localparam int X_W    = $clog2(IMG_W);
    localparam int Y_W    = $clog2(IMG_H);
    localparam int WAIT_W = $clog2(PROC_LAT + 2);

    seq_state_e        state;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [TAP_W-1:0]  tap;
    logic [WAIT_W-1:0] wait_cnt;
    logic              two_src;
    logic              busy_q;
    logic              rd_en_q;
    logic              wr_en_q;

    logic              last_x;
    logic              last_y;
    logic [X_W-1:0]    next_x;
    logic [Y_W-1:0]    next_y;
    logic [X_W-1:0]    gen_x;
    logic [Y_W-1:0]    gen_y;
    logic [TAP_W-1:0]  gen_k;
    logic [ADDR_W-1:0] gen_addr;

    assign last_x = (x == X_W'(IMG_W - 1));
    assign last_y = (y == Y_W'(IMG_H - 1));
    assign next_x = last_x ? '0 : x + X_W'(1);
    assign next_y = last_x ? y + Y_W'(1) : y;

    // Address for the read issued in the next cycle, whichever state we come from.
    always_comb begin
        gen_x = x;
        gen_y = y;
        gen_k = '0;
        case (state)
            S_IDLE: begin
                gen_x = '0;
                gen_y = '0;
            end
            S_FETCH_A, S_FETCH_B:
                gen_k = (tap == TAP_W'(CELL_TAPS)) ? '0 : tap + TAP_W'(1);
            S_WRITE: begin
                gen_x = next_x;
                gen_y = next_y;
            end
            default: ;
        endcase
    end

    cell_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_addr_gen (
        .x    (gen_x),
        .y    (gen_y),
        .k    (gen_k),
        .addr (gen_addr)
    );

    // abort must silence the strobes in the very cycle it is seen, so that a
    // write already scheduled for this cycle never reaches memory.
    assign busy  = busy_q  & ~abort;
    assign rd_en = rd_en_q & ~abort;
    assign wr_en = wr_en_q & ~abort;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            tap      <= '0;
            wait_cnt <= '0;
            two_src  <= 1'b0;
            busy_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            done     <= 1'b0;
            rd_sel   <= 1'b0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cell_a   <= '0;
            cell_b   <= '0;
            user_a   <= '0;
            opcode   <= '0;
        end else if (abort) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opcode  <= cfg_opcode;
                        user_a  <= cfg_user;
                        two_src <= cfg_two_src;
                        cell_b  <= '0;
                        x       <= '0;
                        y       <= '0;
                        tap     <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd_sel  <= 1'b0;
                        rd_addr <= gen_addr;
                        state   <= S_FETCH_A;
                    end
                end

                S_FETCH_A, S_FETCH_B: begin
                    // Read data lags its strobe by one cycle, so cycle t fills tap t-1.
                    if (tap != '0) begin
                        if (state == S_FETCH_A)
                            cell_a[PIXEL_W*(int'(tap)-1) +: PIXEL_W] <= rd_data;
                        else
                            cell_b[PIXEL_W*(int'(tap)-1) +: PIXEL_W] <= rd_data;
                    end
                    if (tap == TAP_W'(CELL_TAPS)) begin
                        tap <= '0;
                        if (state == S_FETCH_A && two_src) begin
                            rd_en_q <= 1'b1;
                            rd_sel  <= 1'b1;
                            rd_addr <= gen_addr;
                            state   <= S_FETCH_B;
                        end else begin
                            rd_en_q  <= 1'b0;
                            rd_sel   <= 1'b0;
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end
                    end else begin
                        tap     <= tap + TAP_W'(1);
                        rd_en_q <= (tap < TAP_W'(CELL_TAPS - 1));
                        if (tap < TAP_W'(CELL_TAPS - 1))
                            rd_addr <= gen_addr;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == WAIT_W'(PROC_LAT)) begin
                        wr_en_q <= 1'b1;
                        wr_data <= proc_pixel;
                        wr_addr <= ADDR_W'(int'(y) * IMG_W + int'(x));
                        state   <= S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    if (last_x && last_y) begin
                        busy_q <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        x       <= next_x;
                        y       <= next_y;
                        tap     <= '0;
                        rd_en_q <= 1'b1;
                        rd_sel  <= 1'b0;
                        rd_addr <= gen_addr;
                        state   <= S_FETCH_A;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_sequencer.sv
// Scoreboard bench for cell_sequencer on a 4x4 image with a one-cycle processor
// model that returns the centre tap of cell_a.
module tb_cell_sequencer;
    import cell_sequencer_pkg::*;

    localparam int W      = 4;
    localparam int H      = 4;
    localparam int NPIX   = W * H;
    localparam int ADDR_W = 4;

    localparam cell_t CELL_P0  = {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    localparam cell_t CELL_P15 = {8'd15, 8'd15, 8'd14, 8'd15, 8'd15, 8'd14, 8'd11, 8'd11, 8'd10};

    typedef struct {
        int      addr;
        pixel_t  data;
        cell_t   ca;
        cell_t   cb;
        opcode_t opc;
        user_t   usr;
        bit      two;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    opcode_t           cfg_opcode;
    user_t             cfg_user;
    logic              cfg_two_src;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    pixel_t            rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_data;
    cell_t             cell_a;
    cell_t             cell_b;
    user_t             user_a;
    opcode_t           opcode;
    pixel_t            proc_pixel;

    pixel_t img_a [NPIX];
    pixel_t img_b [NPIX];
    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     rd_idx = 0;
    int     wr_cnt = 0;
    int     done_cnt = 0;
    logic [17:0] sel_bits = '0;
    bit     ramp = 1'b0;

    cell_sequencer #(
        .IMG_W    (W),
        .IMG_H    (H),
        .PROC_LAT (1),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_opcode  (cfg_opcode),
        .cfg_user    (cfg_user),
        .cfg_two_src (cfg_two_src),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_sel      (rd_sel),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cell_a      (cell_a),
        .cell_b      (cell_b),
        .user_a      (user_a),
        .opcode      (opcode),
        .proc_pixel  (proc_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Image memory: data valid one cycle after the strobe.
    always @(posedge clk) if (rd_en) rd_data <= rd_sel ? img_b[rd_addr] : img_a[rd_addr];

    // Processor model, one cycle of latency: centre tap of cell_a.
    always @(posedge clk) proc_pixel <= cell_a[39:32];

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int tap_addr(input int p, input int k);
        int xx;
        int yy;
        xx = clampi(p % W + k % 3 - 1, W - 1);
        yy = clampi(p / W + k / 3 - 1, H - 1);
        return yy * W + xx;
    endfunction

    function automatic cell_t model_cell(input int p, input bit use_b);
        cell_t c;
        c = '0;
        for (int k = 0; k < CELL_TAPS; k++)
            c[8*k +: 8] = use_b ? img_b[tap_addr(p, k)] : img_a[tap_addr(p, k)];
        return c;
    endfunction

    task automatic observe();
        exp_t e;
        if (rd_en || wr_en) check("rd_wr_exclusive", rd_en & wr_en, 0);
        if (rd_en) begin
            check("rd_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                check("rd_addr", rd_addr, tap_addr(sb[0].addr, rd_idx % 9));
                sel_bits = {sel_bits[16:0], rd_sel};
                rd_idx++;
            end
        end
        if (wr_en) begin
            check("wr_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
                check("cell_a", cell_a, e.ca);
                check("cell_b", cell_b, e.cb);
                check("opcode", opcode, e.opc);
                check("user_a", user_a, e.usr);
                check("rd_count", rd_idx, e.two ? 18 : 9);
                check("rd_sel_seq", sel_bits, e.two ? 18'h001FF : 18'h0);
                if (ramp && e.addr == 0)  check("cell_p0_literal", cell_a, CELL_P0);
                if (ramp && e.addr == 15) check("cell_p15_literal", cell_a, CELL_P15);
            end
            rd_idx   = 0;
            sel_bits = '0;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            check("done_busy_low", busy, 0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
    endtask

    task automatic flush();
        sb.delete();
        rd_idx   = 0;
        sel_bits = '0;
    endtask

    task automatic push_job(input bit two, input opcode_t opc, input user_t usr);
        exp_t e;
        for (int p = 0; p < NPIX; p++) begin
            e.addr = p;
            e.data = img_a[p];
            e.ca   = model_cell(p, 1'b0);
            e.cb   = two ? model_cell(p, 1'b1) : '0;
            e.opc  = opc;
            e.usr  = usr;
            e.two  = two;
            sb.push_back(e);
        end
    endtask

    // Called right after a step(); leaves the bench at the negedge of the first busy cycle.
    task automatic kick(input bit two, input opcode_t opc, input user_t usr);
        #1;
        cfg_two_src = two;
        cfg_opcode  = opc;
        cfg_user    = usr;
        start       = 1'b1;
        step();
        check("busy_rise", busy, 1);
        #1 start = 1'b0;
    endtask

    task automatic run_job(input bit two, input opcode_t opc, input user_t usr, input bit disturb);
        int t0;
        int w0;
        int d0;
        bit got;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_job(two, opc, usr);
        kick(two, opc, usr);
        t0  = cyc;
        got = 1'b0;
        for (int n = 0; n < 1000 && !got; n++) begin
            step();
            if (done) begin
                got = 1'b1;
                check("done_latency", cyc - t0, NPIX * (two ? 23 : 13));
            end
            #1;
            start = disturb && (n == 40);
            if (disturb && n == 40) begin
                cfg_opcode = ~opc;
                cfg_user   = ~usr;
            end
        end
        if (!got) check("done_timeout", 0, 1);
        check("write_count", wr_cnt - w0, NPIX);
        repeat (20) step();
        check("done_once", done_cnt - d0, 1);
        check("idle_after_job", busy, 0);
        check("sb_drained", sb.size(), 0);
        flush();
    endtask

    initial begin
        int w1;
        int d1;
        bit hit;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_opcode = '0; cfg_user = '0; cfg_two_src = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            img_a[i] = pixel_t'(i);
            img_b[i] = 8'd255 - pixel_t'(i);
        end

        repeat (3) step();
        check("reset_outputs", {busy, done, rd_en, rd_sel, rd_addr, wr_en, wr_addr, wr_data,
                                cell_a, cell_b, user_a, opcode}, '0);
        #1 rst = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // start and abort together in IDLE: nothing starts
        #1; start = 1'b1; abort = 1'b1; cfg_opcode = 4'h3;
        step();
        check("start_abort_busy", busy, 0);
        #1; start = 1'b0; abort = 1'b0;
        step();
        check("start_abort_idle", busy, 0);
        check("start_abort_opcode", opcode, 0);

        // ramp image, single source
        ramp = 1'b1;
        run_job(1'b0, 4'h3, 8'h5A, 1'b0);
        ramp = 1'b0;

        // two sources, B = 255 - A
        run_job(1'b1, 4'h7, 8'h11, 1'b0);

        // abort during FETCH_B of pixel 5
        w1 = wr_cnt;
        push_job(1'b1, 4'h2, 8'h22);
        kick(1'b1, 4'h2, 8'h22);
        hit = 1'b0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            step();
            if (wr_cnt - w1 == 5 && rd_en && rd_sel) hit = 1'b1;
        end
        check("abort_point_reached", hit, 1);
        #1 abort = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        #1 abort = 1'b0;
        w1 = wr_cnt;
        d1 = done_cnt;
        repeat (40) step();
        check("abort_no_writes", wr_cnt, w1);
        check("abort_no_done", done_cnt, d1);
        check("abort_idle", busy, 0);
        flush();
        run_job(1'b0, 4'h5, 8'h33, 1'b0);

        // random image, start pulse and opcode change mid-job
        for (int i = 0; i < NPIX; i++) begin
            img_a[i] = pixel_t'($urandom_range(0, 255));
            img_b[i] = 8'd255 - img_a[i];
        end
        run_job(1'b0, 4'h9, 8'hC3, 1'b1);

        // reset during WAIT of pixel 0
        push_job(1'b0, 4'h6, 8'h44);
        kick(1'b0, 4'h6, 8'h44);
        repeat (10) step();
        check("pre_reset_in_wait", {busy, rd_en, wr_en}, 3'b100);
        #1 rst = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, rd_en, rd_sel, rd_addr, wr_en, wr_addr, wr_data,
                                      cell_a, cell_b, user_a, opcode}, '0);
        repeat (2) step();
        #1 rst = 1'b1;
        flush();
        w1 = wr_cnt;
        repeat (5) step();
        check("post_reset_idle", {busy, done}, 2'b00);
        check("post_reset_no_writes", wr_cnt, w1);
        run_job(1'b1, 4'hA, 8'h55, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
